// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: push/pop FIFO front end for the 8x10 single-clock dual-port RAM.
// Drives the RAM write port (data_a/addr_wa/we_a), read port (addr_ra/re_a) and
// the 4-bit RAM clear control, and tracks the RAM's 1-cycle read latency.
// Optional sticky overflow/underflow flags: define RAM_FIFO_ERR_EN.
// DEPTH must equal 2**ADDR_W; pointers wrap by natural binary overflow.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ready,
  output logic              ovf,
  output logic              udf,
  output logic [DATA_W-1:0] data_a,
  output logic [ADDR_W-1:0] addr_wa,
  output logic [ADDR_W-1:0] addr_ra,
  output logic              we_a,
  output logic              re_a,
  output logic [3:0]        state,
  input  logic [DATA_W-1:0] q_a
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam logic [3:0] RAM_CLEAR = 4'b0001;
  localparam logic [3:0] RAM_IDLE  = 4'b0000;

  logic [0:0]        r_fsm;
  logic [0:0]        w_fsm_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_rd_valid;

  logic w_ready;
  logic w_full;
  logic w_empty;
  logic w_flush;
  logic w_push_acc;
  logic w_pop_acc;
  logic [3:0] w_ram_ctl;

  // Occupancy decode
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == CNT_W'(0));

  // Flush request from S_RUN; rst is handled separately with higher priority
  assign w_flush = w_ready & clr;

  // Request acceptance; rst and clr both drop any push/pop in the same cycle.
  // A push into a full FIFO is legal only when a pop frees the slot at the same time.
  assign w_pop_acc  = w_ready & ~rst & ~clr & pop & ~w_empty;
  assign w_push_acc = w_ready & ~rst & ~clr & push & (~w_full | w_pop_acc);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_CLEAR;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state and per-state outputs; S_CLEAR lasts exactly one cycle
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_ready   = 1'b0;
    w_ram_ctl = RAM_IDLE;
    case (r_fsm)
      S_CLEAR: begin
        w_ram_ctl = RAM_CLEAR;
        w_fsm_nxt = S_RUN;
      end
      S_RUN: begin
        w_ready = 1'b1;
        if (clr) begin
          w_fsm_nxt = S_CLEAR;
        end
      end
      default: begin
        w_fsm_nxt = S_CLEAR;
      end
    endcase
  end

  // Circular write pointer
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
    end else if (w_push_acc) begin
      r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
    end
  end

  // Circular read pointer
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_rd_ptr <= '0;
    end else if (w_pop_acc) begin
      r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
    end
  end

  // Occupancy counter; push+pop together leaves it unchanged
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-valid tracks the RAM's one-cycle read latency; a flush does not
  // cancel a read already issued, reset does
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop_acc;
    end
  end

`ifdef RAM_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Sticky overflow/underflow flags, cleared only by rst or a flush
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (w_ready) begin
      if (push && !w_push_acc) begin
        r_ovf <= 1'b1;
      end
      if (pop && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  // RAM port drive; idle addresses hold the pointers so values stay deterministic
  assign data_a  = push_data;
  assign addr_wa = r_wr_ptr;
  assign addr_ra = r_rd_ptr;
  assign we_a    = w_push_acc;
  assign re_a    = w_pop_acc;
  assign state   = w_ram_ctl;

  // Upstream status
  assign ready    = w_ready;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_valid ? q_a : '0;

endmodule
